// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Supports burst lock, routes read returns to their issuer and counts contention cycles.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RAM_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_t;

  req_id_t     r_last_gnt;
  req_id_t     r_rd_owner;
  logic        r_gnt_prev;
  logic        r_rd_pend;
  logic [15:0] r_conflict_cnt;

  logic    w_lock_hold;
  logic    w_gnt0;
  logic    w_gnt1;
  logic    w_any_gnt;
  logic    w_we;
  logic    w_rd_gnt;
  req_id_t w_winner;
  logic    w_unused;

  // Only the low RAM_AW address bits reach the RAM; the rest wrap.
  assign w_unused = ^{m0_addr[ADDR_W-1:RAM_AW], m1_addr[ADDR_W-1:RAM_AW]};

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_lock_hold = r_gnt_prev &&
                  ((r_last_gnt == REQ0) ? (m0_req && m0_lock) : (m1_req && m1_lock));
    if (!rst) begin
      if (w_lock_hold) begin
        w_gnt0 = (r_last_gnt == REQ0);
        w_gnt1 = (r_last_gnt == REQ1);
      end else if (m0_req && m1_req) begin
        w_gnt0 = (r_last_gnt == REQ1);
        w_gnt1 = (r_last_gnt == REQ0);
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign w_winner  = w_gnt1 ? REQ1 : REQ0;
  assign w_we      = w_gnt1 ? m1_we : m0_we;
  assign w_rd_gnt  = w_any_gnt & ~w_we;

  // With no grant the mux rests on requester 0; mem_wren keeps the RAM idle.
  assign mem_addr  = w_gnt1 ? m1_addr[RAM_AW-1:0] : m0_addr[RAM_AW-1:0];
  assign mem_wdata = w_gnt1 ? m1_wdata : m0_wdata;
  assign mem_wren  = w_any_gnt & w_we;

  assign m0_gnt       = w_gnt0;
  assign m1_gnt       = w_gnt1;
  assign m0_rdata     = mem_q;
  assign m1_rdata     = mem_q;
  assign m0_rvalid    = r_rd_pend && (r_rd_owner == REQ0);
  assign m1_rvalid    = r_rd_pend && (r_rd_owner == REQ1);
  assign conflict_cnt = r_conflict_cnt;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt     <= REQ1;
      r_rd_owner     <= REQ0;
      r_gnt_prev     <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_conflict_cnt <= 16'd0;
    end else begin
      r_gnt_prev <= w_any_gnt;
      r_rd_pend  <= w_rd_gnt;
      if (w_any_gnt) r_last_gnt <= w_winner;
      if (w_rd_gnt)  r_rd_owner <= w_winner;
      if (m0_req && m1_req && (r_conflict_cnt != 16'hFFFF))
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory RAM (synchronous, one-cycle read latency, 2^RAM_AW words of DATA_W).
- Requester 0 is the scalar pipeline MEM stage; requester 1 is the vector/DMA load-store unit.
- Each cycle the arbiter picks at most one access using round-robin priority, with an optional lock for bursts.
- It routes returned read data to the issuing requester and counts contention cycles.

Parameters:
- ADDR_W, 32, requester byte/word address width
- DATA_W, 32, data width
- RAM_AW, 6, RAM word-address width; the low RAM_AW address bits are used

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- m0_req  in  1  requester 0 access request
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_lock  in  1  requester 0 holds the grant while asserted with m0_req
- m0_addr  in  ADDR_W  requester 0 address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  requester 0 access accepted this cycle
- m0_rdata  out  DATA_W  requester 0 read data
- m0_rvalid  out  1  m0_rdata valid
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as requester 0, for requester 1
- mem_addr  out  RAM_AW  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data, valid one cycle after address is presented
- conflict_cnt  out  16  saturating count of cycles where both requests were asserted

Behaviour:
- Grant logic is combinational from the current requests and registered state. At most one of m0_gnt/m1_gnt is high in any cycle.
- Single request: that requester is granted.
- Both requesting, no active lock: the requester not granted most recently wins (last_gnt register).
- Lock:
  - If the requester granted in the previous cycle still has req=1 and lock=1, it keeps the grant regardless of the other request.
  - last_gnt does not toggle while a lock holds.
  - Lock is ignored when req=0.
- Memory drive:
  - mem_addr = winner addr[RAM_AW-1:0] (upper bits ignored, address wraps).
  - mem_wdata = winner wdata.
  - mem_wren = gnt & we.
  - With no grant: mem_wren=0 and mem_addr/mem_wdata hold the requester 0 values (don't-care for the RAM).
- A granted access is complete in its grant cycle. A requester must hold req/addr/wdata/we stable until it sees gnt.
- Read return:
  - A granted read sets registered rd_pend=1 and rd_owner=winner on the rising edge.
  - The next cycle, rvalid of rd_owner is 1 for exactly one cycle; the other requester's rvalid is 0.
  - Both mX_rdata ports are driven with mem_q.
  - Back-to-back reads (either requester) give a continuous rvalid stream, one per grant, in grant order.
- Writes never produce rvalid. A write granted directly after a read does not disturb the pending return.
- A read and a write to the same word in consecutive cycles return the old data (RAM read-before-write timing is not bypassed).
- conflict_cnt increments each cycle with m0_req & m1_req, and saturates at 0xFFFF.
- Reset (asynchronous, active-high), while rst=1:
  - last_gnt=1, so requester 0 wins the first contention.
  - rd_pend=0, rd_owner=0, lock-hold state cleared, conflict_cnt=0.
  - m0_gnt=m1_gnt=0, mem_wren=0, m0_rvalid=m1_rvalid=0.
  - mX_rdata follows mem_q (don't-care).
- Reset mid-operation: a pending read return is discarded (no rvalid after rst deasserts). The first cycle after release arbitrates normally.

Test Plan:
- Reset, then m0 reads addr 0x04 alone → m0_gnt=1 same cycle, mem_addr=4, mem_wren=0; next cycle m0_rvalid=1, m0_rdata=RAM[4], m1_rvalid=0.
- m1 writes 0xDEADBEEF to addr 0x47 → mem_addr=0x07 (wrap), mem_wren=1, m1_gnt=1; no rvalid follows; a later m0 read of addr 7 returns 0xDEADBEEF.
- Both request continuously for 6 cycles, no lock, first contention after reset → grants alternate m0,m1,m0,m1,m0,m1; conflict_cnt=6; rvalid follows each read grant by one cycle to the correct owner.
- m1 asserts lock with req for 4 cycles while m0 requests → m1_gnt=1 for all 4 cycles, m0_gnt=0; on m1 release, m0 is granted the next cycle.
- m0 read granted, rst pulsed high for one cycle before the return cycle → no m0_rvalid; gnt=0 and mem_wren=0 during rst; conflict_cnt=0.
- Hold both requests for 70000 cycles → conflict_cnt saturates at 0xFFFF with no wrap.
